// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// CFG_DATA_WIDTH sets the default FIFO word width.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 9
`endif

package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } uart_frame_cfg_t;

  function automatic logic [3:0] clamp_data_bits(
    input logic [3:0] bits,
    input logic [3:0] max_bits
  );
    if (bits < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (bits > max_bits) return max_bits;
    return bits;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Show-ahead TX FIFO read port.
// master = consumer (pops), slave = FIFO.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH
);
  logic                  tx_fifo_empty;
  logic [DATA_WIDTH-1:0] tx_fifo_data_out;
  logic                  tx_fifo_rd_req;

  modport master (
    input  tx_fifo_empty,
    input  tx_fifo_data_out,
    output tx_fifo_rd_req
  );

  modport slave (
    output tx_fifo_empty,
    output tx_fifo_data_out,
    input  tx_fifo_rd_req
  );
endinterface

// File: rtl/uart_parity_gen.sv
// Parity over the low data_bits bits of a character.
// odd=1 inverts the XOR result.
module uart_parity_gen #(
  parameter int MAX_DATA_BITS = 9
) (
  input  logic [MAX_DATA_BITS-1:0] data,
  input  logic [3:0]               data_bits,
  input  logic                     odd,
  output logic                     parity
);

  always_comb begin
    parity = odd;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) < data_bits) parity = parity ^ data[i];
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine with run-time frame format.
// Line break support is built when UART_TX_BREAK_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = `CFG_DATA_WIDTH,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clken,
  input  logic       cts_n,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  input  logic       cfg_stop2,
  input  logic       break_req,
  uart_tx_engine_if.master fifo,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [3:0] MAXB = 4'(MAX_DATA_BITS);

  tx_state_e               state, state_n;
  logic [3:0]              bit_cnt, bit_cnt_n;
  logic [MAX_DATA_BITS-1:0] shreg, shreg_n;
  logic [MAX_DATA_BITS-1:0] data_q, data_n;
  uart_frame_cfg_t         cfg_q, cfg_n;
  logic                    tx_n;
  logic                    load;
  logic                    frame_end;
  logic                    idle_chk;
  logic                    parity;
  logic [3:0]              last_bit;
  logic [DATA_WIDTH-1:0]   word_full;
  logic [MAX_DATA_BITS-1:0] word;

  assign word_full = fifo.tx_fifo_data_out;
  assign word      = word_full[MAX_DATA_BITS-1:0];
  assign last_bit  = cfg_q.data_bits - 4'd1;

`ifndef UART_TX_BREAK_EN
  logic unused_break;
  assign unused_break = break_req;
`endif

  uart_parity_gen #(
    .MAX_DATA_BITS(MAX_DATA_BITS)
  ) u_parity (
    .data     (data_q),
    .data_bits(cfg_q.data_bits),
    .odd      (cfg_q.parity_odd),
    .parity   (parity)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      cfg_q   <= cfg_n;
      tx      <= tx_n;
      tx_done <= frame_end;
    end
  end

  // tx_n is the level the line takes after this tick
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = data_q;
    cfg_n     = cfg_q;
    tx_n      = tx;
    load      = 1'b0;
    frame_end = 1'b0;
    idle_chk  = 1'b0;
    if (clken) begin
      unique case (state)
        IDLE: idle_chk = 1'b1;
        START: begin
          tx_n      = shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt == last_bit) begin
            bit_cnt_n = '0;
            if (cfg_q.parity_en) begin
              state_n = PARITY;
              tx_n    = parity;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            tx_n      = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
        PARITY: begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
        STOP: begin
          if (cfg_q.stop2 && bit_cnt == 4'd0) begin
            bit_cnt_n = 4'd1;
          end else begin
            frame_end = 1'b1;
            idle_chk  = 1'b1;
            state_n   = IDLE;
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!break_req) begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      endcase
      if (idle_chk) begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_n = BREAK;
          tx_n    = 1'b0;
        end else
`endif
        if (!fifo.tx_fifo_empty && !cts_n) begin
          load            = 1'b1;
          state_n         = START;
          tx_n            = 1'b0;
          bit_cnt_n       = '0;
          shreg_n         = word;
          data_n          = word;
          cfg_n.data_bits = clamp_data_bits(cfg_data_bits, MAXB);
          cfg_n.parity_en  = cfg_parity_en;
          cfg_n.parity_odd = cfg_parity_odd;
          cfg_n.stop2      = cfg_stop2;
        end
      end
    end
  end

  always_comb begin
    fifo.tx_fifo_rd_req = load && !reset;
    tx_busy             = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised self-checking bench for uart_tx_engine.
// Line bits are sampled once per baud tick and compared to a frame model.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       clken = 1'b0;
  logic       cts_n;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       break_req;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_engine_if #(.DATA_WIDTH(9)) fifo_if ();

  uart_tx_engine #(
    .DATA_WIDTH   (9),
    .MAX_DATA_BITS(9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clken         (clken),
    .cts_n         (cts_n),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .break_req     (break_req),
    .fifo          (fifo_if.master),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: main writes mem/wr_ptr, monitor advances rd_ptr
  logic [8:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_if.tx_fifo_empty    = (rd_ptr == wr_ptr);
  assign fifo_if.tx_fifo_data_out = mem[rd_ptr % 64];

  int div = 16;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (cnt >= div - 1) begin
        clken = 1'b1;
        cnt   = 0;
      end else begin
        clken = 1'b0;
        cnt++;
      end
    end
  end

  logic cap_q[$];
  int   done_cnt = 0;
  int   rd_cnt   = 0;
  int   bad_pop  = 0;
  initial begin
    bit tick_pend;
    bit pop;
    tick_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_pend) cap_q.push_back(tx);
      tick_pend = clken;
      if (tx_done) done_cnt++;
      pop = fifo_if.tx_fifo_rd_req;
      if (pop) begin
        rd_cnt++;
        if (fifo_if.tx_fifo_empty) bad_pop++;
      end
      @(posedge clk);
      #1;
      if (pop) rd_ptr++;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sync();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [8:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic set_cfg(input int bits, input bit pe, input bit po,
                         input bit s2);
    cfg_data_bits  = 4'(bits);
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
  endtask

  // Frame as seen on the wire, from the format rules alone
  task automatic model(input logic [8:0] w, input int bits, input bit pe,
                       input bit po, input bit s2);
    int nb;
    bit p;
    nb = (bits < 5) ? 5 : (bits > 9) ? 9 : bits;
    p  = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(w[i]);
      p = p ^ w[i];
    end
    if (pe) exp_q.push_back(p ^ po);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 20000 && done_cnt < target; i++) sync();
    chk({tag, "_done"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_caps(input int n);
    for (int i = 0; i < 20000 && cap_q.size() < n; i++) sync();
  endtask

  task automatic check_stream(input string tag, input int base);
    logic [63:0] o;
    logic [63:0] e;
    o = '0;
    e = '0;
    for (int i = 0; i < exp_q.size() && i < 64; i++) begin
      e[i] = exp_q[i];
      o[i] = (base + i < cap_q.size()) ? cap_q[base + i] : 1'bx;
    end
    chk({tag, "_bits"}, o, e);
  endtask

  task automatic run_frame(input string tag, input logic [8:0] w,
                           input int bits, input bit pe, input bit po,
                           input bit s2);
    int base;
    int d0;
    int r0;
    exp_q.delete();
    model(w, bits, pe, po, s2);
    set_cfg(bits, pe, po, s2);
    base = cap_q.size();
    d0   = done_cnt;
    r0   = rd_cnt;
    push(w);
    wait_caps(base + 2);
    chk({tag, "_busy1"}, 64'(tx_busy), 64'(1));
    wait_done(tag, d0 + 1);
    chk({tag, "_len"}, 64'(cap_q.size() - base - 1), 64'(exp_q.size()));
    chk({tag, "_busy0"}, 64'(tx_busy), 64'(0));
    check_stream(tag, base);
    chk({tag, "_rd"}, 64'(rd_cnt - r0), 64'(1));
  endtask

  initial begin
    int base;
    int d0;
    int r0;
    int bits;
    bit pe;
    bit po;
    bit s2;
    logic [8:0] w;
    logic [63:0] o;

    reset     = 1'b1;
    cts_n     = 1'b0;
    break_req = 1'b0;
    set_cfg(8, 0, 0, 0);
    repeat (3) sync();
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_busy", 64'(tx_busy), 64'(0));
    chk("rst_done", 64'(tx_done), 64'(0));
    chk("rst_rd", 64'(fifo_if.tx_fifo_rd_req), 64'(0));
    reset = 1'b0;
    repeat (3) sync();

    div = 16;
    run_frame("8N1", 9'h055, 8, 0, 0, 0);
    run_frame("7E2", 9'h041, 7, 1, 0, 1);
    run_frame("5O1", 9'h01F, 5, 1, 1, 0);

    for (int k = 0; k < 8; k++) begin
      div = int'($urandom_range(1, 4));
      w   = 9'($urandom);
      run_frame($sformatf("rnd%0d", k), w, int'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    // three queued words go out with no idle tick between frames
    div  = 2;
    bits = int'($urandom_range(5, 9));
    pe   = 1'($urandom);
    po   = 1'($urandom);
    s2   = 1'($urandom);
    set_cfg(bits, pe, po, s2);
    exp_q.delete();
    d0   = done_cnt;
    r0   = rd_cnt;
    base = cap_q.size();
    for (int k = 0; k < 3; k++) begin
      w = 9'($urandom);
      model(w, bits, pe, po, s2);
      push(w);
    end
    wait_done("b2b", d0 + 3);
    chk("b2b_len", 64'(cap_q.size() - base - 1), 64'(exp_q.size()));
    check_stream("b2b", base);
    chk("b2b_rd", 64'(rd_cnt - r0), 64'(3));

    // flow control holds the line idle, then is ignored mid-frame
    div   = 3;
    cts_n = 1'b1;
    set_cfg(8, 1, 0, 0);
    w     = 9'($urandom);
    r0    = rd_cnt;
    d0    = done_cnt;
    base  = cap_q.size();
    push(w);
    wait_caps(base + 20);
    chk("cts_rd", 64'(rd_cnt - r0), 64'(0));
    o = '0;
    for (int i = 0; i < 20; i++) o[i] = cap_q[base + i];
    chk("cts_idle", o, 64'h00000000000FFFFF);
    chk("cts_busy", 64'(tx_busy), 64'(0));
    exp_q.delete();
    model(w, 8, 1, 0, 0);
    cts_n = 1'b0;
    base  = cap_q.size();
    wait_caps(base + 3);
    cts_n = 1'b1;
    wait_done("cts", d0 + 1);
    check_stream("cts", base);
    chk("cts_rd1", 64'(rd_cnt - r0), 64'(1));
    cts_n = 1'b0;

    // reset during data bit 3 drops the frame without another pop
    div = 4;
    set_cfg(8, 0, 0, 0);
    r0   = rd_cnt;
    w    = 9'($urandom) & 9'h1F7;
    base = cap_q.size();
    push(w);
    w = 9'($urandom);
    push(w);
    wait_caps(base + 5);
    chk("mid_bit3", 64'(tx), 64'(0));
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", 64'(tx), 64'(1));
    chk("mid_rst_busy", 64'(tx_busy), 64'(0));
    repeat (12) sync();
    chk("mid_rst_rd", 64'(rd_cnt - r0), 64'(1));
    exp_q.delete();
    model(w, 8, 0, 0, 0);
    d0    = done_cnt;
    reset = 1'b0;
    base  = cap_q.size();
    wait_done("post_rst", d0 + 1);
    check_stream("post_rst", base);
    chk("post_rst_rd", 64'(rd_cnt - r0), 64'(2));

`ifdef UART_TX_BREAK_EN
    div = 2;
    set_cfg(8, 0, 0, 0);
    w = 9'($urandom);
    exp_q.delete();
    model(w, 8, 0, 0, 0);
    d0   = done_cnt;
    base = cap_q.size();
    push(w);
    wait_caps(base + 3);
    break_req = 1'b1;
    wait_done("brk", d0 + 1);
    check_stream("brk", base);
    base = cap_q.size();
    wait_caps(base + 5);
    o = '0;
    for (int i = 0; i < 5; i++) o[i] = cap_q[base + i];
    chk("brk_low", o, 64'h0);
    chk("brk_busy", 64'(tx_busy), 64'(1));
    break_req = 1'b0;
    base = cap_q.size();
    wait_caps(base + 2);
    chk("brk_rel_tx", 64'(tx), 64'(1));
    chk("brk_rel_busy", 64'(tx_busy), 64'(0));
`else
    break_req = 1'b1;
    div = 2;
    run_frame("nobrk", 9'($urandom), 8, 1, 1, 1);
    break_req = 1'b0;
`endif

    chk("no_empty_pop", 64'(bad_pop), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
